// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format encodings for the immediate decode stage.
package imm_pkg;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_CSR   = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: format classification and sign/zero extension to XLEN.
// SYSTEM decodes as CSR format only when IMM_GEN_ZICSR_EN is defined.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
`ifdef IMM_GEN_ZICSR_EN
  ,
  output logic [4:0]      zimm
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  imm_fmt_e   fmt_e;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign fmt      = fmt_e;

`ifdef IMM_GEN_ZICSR_EN
  assign zimm = instr[19:15];
`endif

  always_comb begin
    imm     = '0;
    fmt_e   = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      LOAD, JALR, MISC_MEM: begin
        fmt_e = IMM_I;
        imm   = XLEN'($signed(instr[31:20]));
      end
      OP_IMM: begin
        if (is_shift) begin
          fmt_e = IMM_SHAMT;
          // RV64 shift amounts carry one more bit
          if (XLEN == 64) imm = XLEN'(instr[25:20]);
          else            imm = XLEN'(instr[24:20]);
        end else begin
          fmt_e = IMM_I;
          imm   = XLEN'($signed(instr[31:20]));
        end
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            fmt_e = IMM_SHAMT;
            imm   = XLEN'(instr[24:20]);
          end else begin
            fmt_e = IMM_I;
            imm   = XLEN'($signed(instr[31:20]));
          end
        end else begin
          illegal = 1'b1;
        end
      end
      STORE: begin
        fmt_e = IMM_S;
        imm   = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      BRANCH: begin
        fmt_e = IMM_B;
        imm   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      JAL: begin
        fmt_e = IMM_J;
        imm   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      LUI, AUIPC: begin
        fmt_e = IMM_U;
        imm   = XLEN'($signed({instr[31:12], 12'h000}));
      end
      OP: ;
`ifdef IMM_GEN_ZICSR_EN
      SYSTEM: begin
        fmt_e = IMM_CSR;
        imm   = XLEN'(instr[31:20]);
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered immediate decode stage: decode + PC-relative target at capture, buffered in a FIFO.
// Define IMM_GEN_ZICSR_EN to decode SYSTEM as CSR format with zimm carried in out_target.
module immediate_decode_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_target,
  output logic [XLEN-1:0]          out_pc,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] cap_target;

`ifdef IMM_GEN_ZICSR_EN
  logic [4:0] dec_zimm;
`endif

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
`ifdef IMM_GEN_ZICSR_EN
    ,
    .zimm    (dec_zimm)
`endif
  );

`ifdef IMM_GEN_ZICSR_EN
  // CSR entries reuse the target slot for the zero-extended zimm field
  assign cap_target = (dec_fmt == IMM_CSR) ? XLEN'(dec_zimm) : in_pc + dec_imm;
`else
  assign cap_target = in_pc + dec_imm;
`endif

  logic [XLEN-1:0] imm_q    [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [2:0]      fmt_q    [DEPTH];
  logic            ill_q    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Readiness looks only at occupancy, never at out_ready
  assign in_ready  = (count_q < FullCount) & ~flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        imm_q[i]    <= '0;
        target_q[i] <= '0;
        pc_q[i]     <= '0;
        fmt_q[i]    <= '0;
        ill_q[i]    <= 1'b0;
      end
    end else if (push) begin
      imm_q[wr_ptr_q]    <= dec_imm;
      target_q[wr_ptr_q] <= cap_target;
      pc_q[wr_ptr_q]     <= in_pc;
      fmt_q[wr_ptr_q]    <= dec_fmt;
      ill_q[wr_ptr_q]    <= dec_illegal;
    end
  end

  assign out_imm     = imm_q[rd_ptr_q];
  assign out_target  = target_q[rd_ptr_q];
  assign out_pc      = pc_q[rd_ptr_q];
  assign out_fmt     = fmt_q[rd_ptr_q];
  assign out_illegal = ill_q[rd_ptr_q];
  assign count       = count_q;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Bench for immediate_decode_stage: directed decode, full/flush scenarios and a random run
// against a behavioural model, on an XLEN=32/DEPTH=2 and an XLEN=64/DEPTH=4 instance.
module tb_immediate_decode_stage;

  localparam int D32 = 2;
  localparam int D64 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] pc64 = '0;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32, opc32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64, opc64;
  logic [2:0]  fmt64;
  logic [2:0]  cnt64;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] target;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  immediate_decode_stage #(.XLEN(32), .DEPTH(D32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(pc64[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32), .out_pc(opc32), .out_fmt(fmt32),
    .out_illegal(ill32), .count(cnt32)
  );

  immediate_decode_stage #(.XLEN(64), .DEPTH(D64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(pc64), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64), .out_pc(opc64), .out_fmt(fmt64),
    .out_illegal(ill64), .count(cnt64)
  );

  function automatic longint sext(input longint v, input int bits);
    longint half;
    half = longint'(1) <<< (bits - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  // Reference decode from the field-placement rules, using integer arithmetic
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                      input int xlen);
    exp_t        e;
    longint      v;
    logic [63:0] mask;
    int          op;
    int          f3;
    bit          shamt;
    e     = '0;
    v     = 0;
    op    = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    shamt = (f3 == 1) || (f3 == 5);
    mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (op)
      'h03, 'h0F, 'h67: begin e.fmt = 3'd1; v = sext(longint'(ins[31:20]), 12); end
      'h13: begin
        if (shamt) begin
          e.fmt = 3'd6;
          v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          e.fmt = 3'd1; v = sext(longint'(ins[31:20]), 12);
        end
      end
      'h1B: begin
        if (xlen != 64) e.ill = 1'b1;
        else if (shamt) begin e.fmt = 3'd6; v = longint'(ins[24:20]); end
        else begin e.fmt = 3'd1; v = sext(longint'(ins[31:20]), 12); end
      end
      'h23: begin
        e.fmt = 3'd2;
        v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end
      'h63: begin
        e.fmt = 3'd3;
        v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                 longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      'h6F: begin
        e.fmt = 3'd5;
        v = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                 longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      'h37, 'h17: begin e.fmt = 3'd4; v = sext(longint'(ins[31:12]) * 4096, 32); end
      'h33: ;
`ifdef IMM_GEN_ZICSR_EN
      'h73: begin e.fmt = 3'd7; v = longint'(ins[31:20]); end
`endif
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v) & mask;
    e.pc  = pc & mask;
    e.target = (e.fmt == 3'd7) ? 64'(ins[19:15]) : ((pc + e.imm) & mask);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q32.delete();
    q64.delete();
  endtask

  task automatic test_reset();
    do_reset();
    in_instr = 32'hFFF0_0093;
    pc64     = 64'h100;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov32, rdy32, cnt32, imm32, tgt32, opc32, fmt32, ill32} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset32: got v=%b r=%b c=%0d imm=%h tgt=%h pc=%h fmt=%0d ill=%b want all zero, r=1",
               ov32, rdy32, cnt32, imm32, tgt32, opc32, fmt32, ill32);
    end
    n_cmp++;
    if ({ov64, rdy64, cnt64, imm64, tgt64, opc64, fmt64, ill64} !==
        {1'b0, 1'b1, 3'd0, 64'd0, 64'd0, 64'd0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset64: got v=%b r=%b c=%0d imm=%h tgt=%h pc=%h fmt=%0d ill=%b want all zero, r=1",
               ov64, rdy64, cnt64, imm64, tgt64, opc64, fmt64, ill64);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef IMM_GEN_ZICSR_EN
  localparam logic [63:0] CsrImm = 64'h300;
  localparam logic [63:0] CsrTgt = 64'h0;
  localparam logic [2:0]  CsrFmt = 3'd7;
  localparam logic        CsrIll = 1'b0;
`else
  localparam logic [63:0] CsrImm = 64'h0;
  localparam logic [63:0] CsrTgt = 64'h80;
  localparam logic [2:0]  CsrFmt = 3'd0;
  localparam logic        CsrIll = 1'b1;
`endif

  task automatic test_directed();
    logic [31:0] ins [8] = '{32'hFFF0_0093, 32'hFE00_0EE3, 32'h0080_006F, 32'h03F0_9093,
                             32'h8000_00B7, 32'h0020_8033, 32'h0010_809B, 32'h3000_2573};
    logic [63:0] pcs [8] = '{64'h100, 64'h200, 64'h300, 64'h0, 64'h0, 64'h40, 64'h40, 64'h80};
    logic [31:0] i32 [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h8, 32'h1F, 32'h8000_0000,
                             32'h0, 32'h0, CsrImm[31:0]};
    logic [31:0] t32 [8] = '{32'hFF, 32'h1FC, 32'h308, 32'h1F, 32'h8000_0000, 32'h40, 32'h40,
                             CsrTgt[31:0]};
    logic [2:0]  f32 [8] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4, 3'd0, 3'd0, CsrFmt};
    logic        l32 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CsrIll};
    logic [63:0] i64 [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h3F,
                             64'hFFFF_FFFF_8000_0000, 64'h0, 64'h1, CsrImm};
    logic [63:0] t64 [8] = '{64'hFF, 64'h1FC, 64'h308, 64'h3F, 64'hFFFF_FFFF_8000_0000,
                             64'h40, 64'h41, CsrTgt};
    logic [2:0]  f64 [8] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4, 3'd0, 3'd1, CsrFmt};
    logic        l64 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CsrIll};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_instr = ins[k];
      pc64     = pcs[k];
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ov32, cnt32, imm32, tgt32, opc32, fmt32, ill32} !==
          {1'b1, 2'd1, i32[k], t32[k], pcs[k][31:0], f32[k], l32[k]}) begin
        n_bad++;
        $display("FAIL dir32[%0d] %h: got v=%b c=%0d imm=%h tgt=%h pc=%h fmt=%0d ill=%b want imm=%h tgt=%h fmt=%0d ill=%b",
                 k, ins[k], ov32, cnt32, imm32, tgt32, opc32, fmt32, ill32,
                 i32[k], t32[k], f32[k], l32[k]);
      end
      n_cmp++;
      if ({ov64, cnt64, imm64, tgt64, opc64, fmt64, ill64} !==
          {1'b1, 3'd1, i64[k], t64[k], pcs[k], f64[k], l64[k]}) begin
        n_bad++;
        $display("FAIL dir64[%0d] %h: got v=%b c=%0d imm=%h tgt=%h pc=%h fmt=%0d ill=%b want imm=%h tgt=%h fmt=%0d ill=%b",
                 k, ins[k], ov64, cnt64, imm64, tgt64, opc64, fmt64, ill64,
                 i64[k], t64[k], f64[k], l64[k]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < D32 + 1; k++) begin
      in_instr = (32'(k + 1) << 20) | 32'h0000_0093;
      pc64     = 64'(k * 4);
      @(posedge clk);
      #1;
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_cmp++;
      if ({ov32, rdy32, cnt32, imm32, opc32} !== {1'b1, 1'b0, 2'd2, 32'd1, 32'd0}) begin
        n_bad++;
        $display("FAIL full_hold[%0d]: got v=%b r=%b c=%0d imm=%h pc=%h want v=1 r=0 c=2 imm=1 pc=0",
                 h, ov32, rdy32, cnt32, imm32, opc32);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (rdy32 !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop_ready: got in_ready=%b want 0", rdy32);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ov32, rdy32, cnt32, imm32, opc32} !== {1'b1, 1'b1, 2'd1, 32'd2, 32'd4}) begin
      n_bad++;
      $display("FAIL full_after_pop: got v=%b r=%b c=%0d imm=%h pc=%h want v=1 r=1 c=1 imm=2 pc=4",
               ov32, rdy32, cnt32, imm32, opc32);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_instr = 32'h0050_0113;
      pc64     = 64'(16 * k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cnt32 !== 2'd2 || cnt64 !== 3'd2) begin
      n_bad++;
      $display("FAIL flush_pre: got c32=%0d c64=%0d want 2 2", cnt32, cnt64);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0070_0193;
    #1;
    n_cmp++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready: got r32=%b r64=%b want 0 0", rdy32, rdy64);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      n_cmp++;
      if ({ov32, cnt32, ov64, cnt64} !== {1'b0, 2'd0, 1'b0, 3'd0}) begin
        n_bad++;
        $display("FAIL flush_empty[%0d]: got v32=%b c32=%0d v64=%b c64=%0d want all 0",
                 h, ov32, cnt32, ov64, cnt64);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37,
                             7'h63, 7'h67, 7'h6F, 7'h73, 7'h13};
    exp_t h32;
    exp_t h64;
    bit   push32, pop32, push64, pop64;
    int   idx;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if ({ov32, cnt32, rdy32} !== {q32.size() > 0, 2'(q32.size()),
                                    (q32.size() < D32) && !flush}) begin
        n_bad++;
        $display("FAIL rand32_ctl cyc%0d: got v=%b c=%0d r=%b want c=%0d",
                 cyc, ov32, cnt32, rdy32, q32.size());
      end
      n_cmp++;
      if ({ov64, cnt64, rdy64} !== {q64.size() > 0, 3'(q64.size()),
                                    (q64.size() < D64) && !flush}) begin
        n_bad++;
        $display("FAIL rand64_ctl cyc%0d: got v=%b c=%0d r=%b want c=%0d",
                 cyc, ov64, cnt64, rdy64, q64.size());
      end
      if (q32.size() > 0) begin
        h32 = q32[0];
        n_cmp++;
        if ({imm32, tgt32, opc32, fmt32, ill32} !==
            {h32.imm[31:0], h32.target[31:0], h32.pc[31:0], h32.fmt, h32.ill}) begin
          n_bad++;
          $display("FAIL rand32_head cyc%0d: got imm=%h tgt=%h pc=%h fmt=%0d ill=%b want imm=%h tgt=%h pc=%h fmt=%0d ill=%b",
                   cyc, imm32, tgt32, opc32, fmt32, ill32, h32.imm[31:0], h32.target[31:0],
                   h32.pc[31:0], h32.fmt, h32.ill);
        end
      end
      if (q64.size() > 0) begin
        h64 = q64[0];
        n_cmp++;
        if ({imm64, tgt64, opc64, fmt64, ill64} !==
            {h64.imm, h64.target, h64.pc, h64.fmt, h64.ill}) begin
          n_bad++;
          $display("FAIL rand64_head cyc%0d: got imm=%h tgt=%h pc=%h fmt=%0d ill=%b want imm=%h tgt=%h pc=%h fmt=%0d ill=%b",
                   cyc, imm64, tgt64, opc64, fmt64, ill64, h64.imm, h64.target, h64.pc,
                   h64.fmt, h64.ill);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = $urandom;
      idx       = $urandom_range(0, 13);
      in_instr[6:0] = (idx == 13) ? 7'($urandom) : ops[idx];
      pc64      = {$urandom, $urandom};
      push32 = in_valid && (q32.size() < D32) && !flush;
      pop32  = (q32.size() > 0) && out_ready && !flush;
      push64 = in_valid && (q64.size() < D64) && !flush;
      pop64  = (q64.size() > 0) && out_ready && !flush;
      @(posedge clk);
      if (flush) begin
        q32.delete();
        q64.delete();
      end else begin
        if (pop32) void'(q32.pop_front());
        if (pop64) void'(q64.pop_front());
        if (push32) q32.push_back(ref_decode(in_instr, pc64, 32));
        if (push64) q64.push_back(ref_decode(in_instr, pc64, 64));
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_full();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
